// File: rtl/result_reader.sv
// Result reader: captures the two result words from the compute block when
// it signals done, then steps a 16-bit display through G, H and a STATUS
// word (capture count / latency) with one step per press of the step key.
module result_reader (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        done,
    input  logic [15:0] g,
    input  logic [15:0] h,
    input  logic        key_n,
    output logic [15:0] disp,
    output logic [1:0]  sel,
    output logic        parity,
    output logic        valid
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        CAPTURE = 3'd2,
        SHOW    = 3'd3,
        HOLD    = 3'd4
    } state_t;

    state_t      state;
    logic [15:0] g_reg;
    logic [15:0] h_reg;
    logic [7:0]  capture_count;
    logic [7:0]  lat_run;   // running count of ARMED cycles
    logic [7:0]  latency;   // lat_run frozen at the last capture

    // 8-bit counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Display index sequence G -> H -> STATUS -> G.
    function automatic logic [1:0] next_sel(input logic [1:0] s);
        return (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

    // Control FSM plus capture registers; advancing sel only on SHOW->HOLD
    // makes each press worth exactly one step however long it is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            g_reg         <= 16'h0000;
            h_reg         <= 16'h0000;
            capture_count <= 8'h00;
            lat_run       <= 8'h00;
            latency       <= 8'h00;
            sel           <= 2'd0;
            valid         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= ARMED;
                        lat_run <= 8'h00;
                    end
                end
                ARMED: begin
                    lat_run <= sat_inc(lat_run);
                    if (done) begin
                        state <= CAPTURE;
                    end else if (!start) begin
                        state <= IDLE;
                    end
                end
                CAPTURE: begin
                    g_reg         <= g;
                    h_reg         <= h;
                    capture_count <= sat_inc(capture_count);
                    latency       <= lat_run;
                    valid         <= 1'b1;
                    sel           <= 2'd0;
                    // A key already down here lands in HOLD, so it cannot step.
                    state         <= key_n ? SHOW : HOLD;
                end
                SHOW: begin
                    if (!start) begin
                        state <= IDLE;
                    end else if (!key_n) begin
                        state <= HOLD;
                        sel   <= next_sel(sel);
                    end
                end
                HOLD: begin
                    if (!start) begin
                        state <= IDLE;
                    end else if (key_n) begin
                        state <= SHOW;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Presented word selected combinationally from the captured registers.
    always_comb begin
        case (sel)
            2'd0:    disp = g_reg;
            2'd1:    disp = h_reg;
            2'd2:    disp = {capture_count, latency};
            default: disp = 16'h0000;
        endcase
    end

    // Odd parity over disp: the pair always carries an odd number of ones.
    always_comb begin
        parity = ~^disp;
    end

endmodule

// File: doc/result_reader.md
RESULT_READER -- requirements
Module: result_reader

Interface
REQ-001 clk  input  1  system clock (CLOCK_50 domain); all state changes on its rising edge.
REQ-002 rst  input  1  synchronous, active-high reset; sampled on rising clk.
REQ-003 start  input  1  level from the operand loader; high = compute block running or finished.
REQ-004 done  input  1  level from the compute block; high = g/h valid.
REQ-005 g  input  16  first result word.
REQ-006 h  input  16  second result word.
REQ-007 key_n  input  1  step button, already debounced, active-low (0 = pressed).
REQ-008 disp  output  16  word currently presented.
REQ-009 sel  output  2  index of presented word: 0 = G, 1 = H, 2 = STATUS.
REQ-010 parity  output  1  odd-parity bit of disp: disp plus parity holds an odd count of ones.
REQ-011 valid  output  1  high once at least one result set has been captured.

Function
REQ-012 States are IDLE, ARMED, CAPTURE, SHOW and HOLD; any unused encoding SHALL return to IDLE next cycle.
REQ-013 IDLE: start=1 -> ARMED; else stay in IDLE.
REQ-014 ARMED: done=1 -> CAPTURE; start=0 -> IDLE; done has priority when both events apply; key_n is ignored.
REQ-015 The latency counter is 8 bits; it clears on IDLE->ARMED, increments once per ARMED cycle, and saturates at 255.
REQ-016 CAPTURE lasts exactly one cycle:
- latch g -> G_reg and h -> H_reg;
- capture_count (8 bits) += 1, saturating at 255;
- freeze the latency counter value into the STATUS word;
- set valid=1 and sel=0;
- next state is HOLD if key_n=0, else SHOW.
REQ-017 done already high on the cycle of IDLE->ARMED SHALL capture after one ARMED cycle, with latency=1.
REQ-018 SHOW: key_n=0 -> HOLD and advance sel 0->1->2->0 (wrap), one step per press.
REQ-019 HOLD: stay until key_n=1, then -> SHOW; no further advance while held.
REQ-020 The advance occurs only on the SHOW->HOLD transition, so one press = one step regardless of press length; a key held through CAPTURE SHALL NOT advance.
REQ-021 In SHOW or HOLD, start=0 -> IDLE; captured registers, sel and valid are retained.
REQ-022 A later start rise re-arms the block and overwrites G_reg, H_reg and latency on the next capture.
REQ-023 disp output mapping:
- disp = G_reg when sel=0;
- disp = H_reg when sel=1;
- disp = {capture_count[7:0], latency[7:0]} when sel=2;
- disp is combinational from sel and the registers.
REQ-024 parity = XNOR-reduction of disp, combinational.
REQ-025 Inputs g and h SHALL be sampled only in CAPTURE; changes at any other time do not affect disp.

Reset
REQ-026 rst=1 at a rising clk SHALL force:
- state=IDLE;
- G_reg=H_reg=0, capture_count=0, latency=0;
- sel=0, valid=0;
- hence disp=0 and parity=1.
REQ-027 rst has priority over every other input, including mid-capture and mid-HOLD.
REQ-028 The first transition out of IDLE SHALL occur no earlier than the first clk edge after rst falls.

Verification
REQ-029 Reset: assert rst for 2 cycles with start=1, done=1 -> disp=0x0000, parity=1, valid=0, sel=0; ARMED is entered on the first edge after release.
REQ-030 Basic capture: start=1; done=1 after 5 ARMED cycles; g=0x1234, h=0x00FF -> disp=0x1234, parity=0, valid=1.
- press 1 -> disp=0x00FF, parity=1;
- press 2 -> disp=0x0105;
- press 3 -> disp=0x1234 (wrap).
REQ-031 Long press: key_n held low for 1000 cycles in SHOW -> sel advances exactly once; release then press again -> exactly one more step.
REQ-032 Immediate done: done=1 already when start rises -> capture with latency=1; key_n=0 during CAPTURE -> HOLD with sel=0 and no advance until release.
REQ-033 Re-run: drop start, change g to 0xAAAA, raise start, done after 3 cycles -> disp=0xAAAA, parity=1, STATUS=0x0203; values held while start=0 remain unchanged until the recapture.
REQ-034 Saturation and mid-operation reset:
- 300 ARMED cycles before done -> latency=0xFF;
- rst in HOLD -> IDLE, all registers zero, valid=0.
